// File: rtl/cabac_binari_sao_seq.sv
// cabac_binari_sao_seq: CTU SAO parameter set to HEVC SAO bin groups; `define SAO_OFFSET_CLIP_EN to clip offsets and flag errors
module cabac_binari_sao_seq #(
  parameter int BIT_DEPTH = 8,
  parameter int OFF_W = 6,
  parameter logic [7:0] CTX_MERGE = 8'd19,
  parameter logic [7:0] CTX_TYPE = 8'd20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sao_valid_i,
  output logic                 sao_ready_o,
  input  logic                 left_avail_i,
  input  logic                 up_avail_i,
  input  logic                 merge_left_i,
  input  logic                 merge_up_i,
  input  logic [3:0]           type_i,
  input  logic [12*OFF_W-1:0]  offset_i,
  input  logic [14:0]          band_i,
  input  logic [3:0]           eo_class_i,
  output logic                 bg_valid_o,
  input  logic                 bg_ready_i,
  output logic [14:0]          bg_o,
  output logic                 bg_last_o,
  output logic                 err_o
);
  localparam int BD = BIT_DEPTH > 10 ? 10 : BIT_DEPTH;
  localparam logic [4:0] CMAX = 5'((1 << (BD - 5)) - 1);

  typedef enum logic [3:0] {IDLE, MRG_L, MRG_U, TYPE, TYPB, OFFS, SIGN, BAND, EOCLS} state_t;

  state_t state_q, state_d, nxt, comp_nx;
  logic adv;
  logic [1:0] c_q, k_q;
  logic [4:0] rem_q;
  logic la_q, ua_q, ml_q, mu_q;
  logic [3:0] type_q, eo_q;
  logic [12*OFF_W-1:0] off_q;
  logic [14:0] band_q;
  logic [1:0] t, t_ch;
  logic on, on_ch, bo, term;
  logic [4:0] a [4];
  logic [4:0] a_cur, len, r, ones, rem_nx;
  logic [3:0] sgn_n, n, o;
  logic [7:0] sgn_b, ub;

  function automatic logic [OFF_W-1:0] abs_of(input logic [OFF_W-1:0] v);
    return v[OFF_W-1] ? -v : v;
  endfunction

`ifdef SAO_OFFSET_CLIP_EN
  function automatic logic over_of(input logic [OFF_W-1:0] v);
    logic [OFF_W-1:0] p;
    p = abs_of(v);
    return p[OFF_W-1] || 32'(p) > 32'(CMAX);
  endfunction

  function automatic logic [4:0] mag_of(input logic [OFF_W-1:0] v);
    return over_of(v) ? CMAX : 5'(abs_of(v));
  endfunction
`else
  function automatic logic [4:0] mag_of(input logic [OFF_W-1:0] v);
    logic [OFF_W-1:0] p;
    p = abs_of(v);
    return p[OFF_W-1] ? CMAX : 5'(p);
  endfunction
`endif

  always_comb begin
    t_ch = type_q[3:2];
    t = c_q == 2'd0 ? type_q[1:0] : t_ch;
    on = t == 2'd1 || t == 2'd2;
    on_ch = t_ch == 2'd1 || t_ch == 2'd2;
    bo = t == 2'd1;
    sgn_n = '0;
    sgn_b = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = mag_of(off_q[(4*c_q+i)*OFF_W +: OFF_W]);
      if (a[i] != 5'd0) begin
        sgn_n = sgn_n + 4'd1;
        sgn_b = {sgn_b[6:0], off_q[(4*c_q+i)*OFF_W+OFF_W-1]};
      end
    end
    a_cur = a[k_q];
    term = a_cur < CMAX;
    len = a_cur + {4'd0, term};
    r = rem_q == 5'd0 ? len : rem_q;
    n = r > 5'd8 ? 4'd8 : r[3:0];
    ones = r - {4'd0, term};
    o = ones > {1'b0, n} ? n : ones[3:0];
    ub = ~(8'hFF >> o) >> (4'd8 - n);
    rem_nx = r - {1'b0, n};
    comp_nx = c_q == 2'd0 ? TYPE : (c_q == 2'd1 && on_ch) ? OFFS : IDLE;
  end

  always_comb begin
    nxt = IDLE;
    adv = 1'b0;
    case (state_q)
      MRG_L: nxt = (la_q && ml_q) ? IDLE : ua_q ? MRG_U : TYPE;
      MRG_U: nxt = (ua_q && mu_q) ? IDLE : TYPE;
      TYPE: begin
        nxt = on ? TYPB : comp_nx;
        adv = !on;
      end
      TYPB: nxt = OFFS;
      OFFS: nxt = (rem_nx != 5'd0 || k_q != 2'd3) ? OFFS : bo ? (sgn_n != 4'd0 ? SIGN : BAND) : c_q != 2'd2 ? EOCLS : comp_nx;
      SIGN: nxt = BAND;
      BAND, EOCLS: begin
        nxt = comp_nx;
        adv = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    state_d = state_q;
    if (state_q == IDLE) state_d = sao_valid_i ? (left_avail_i ? MRG_L : up_avail_i ? MRG_U : TYPE) : IDLE;
    else if (bg_ready_i) state_d = nxt;
  end

  always_comb begin
    bg_o = '0;
    case (state_q)
      MRG_L: bg_o = {2'b00, ml_q, 4'd1, CTX_MERGE};
      MRG_U: bg_o = {2'b00, mu_q, 4'd1, CTX_MERGE};
      TYPE:  bg_o = {2'b00, on, 4'd1, CTX_TYPE};
      TYPB:  bg_o = {3'b100, 4'd1, 7'd0, !bo};
      OFFS:  bg_o = {3'b100, n, ub};
      SIGN:  bg_o = {3'b100, sgn_n, sgn_b};
      BAND:  bg_o = {3'b100, 4'd5, 3'd0, band_q[5*c_q +: 5]};
      EOCLS: bg_o = {3'b100, 4'd2, 6'd0, (c_q == 2'd0 ? eo_q[1:0] : eo_q[3:2])};
      default: bg_o = '0;
    endcase
  end

  assign sao_ready_o = state_q == IDLE;
  assign bg_valid_o = state_q != IDLE;
  assign bg_last_o = bg_valid_o && nxt == IDLE;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {la_q, ua_q, ml_q, mu_q} <= '0;
      type_q <= '0;
      eo_q <= '0;
      off_q <= '0;
      band_q <= '0;
      c_q <= '0;
      k_q <= '0;
      rem_q <= '0;
    end else if (state_q == IDLE && sao_valid_i) begin
      {la_q, ua_q, ml_q, mu_q} <= {left_avail_i, up_avail_i, merge_left_i, merge_up_i};
      type_q <= type_i;
      eo_q <= eo_class_i;
      off_q <= offset_i;
      band_q <= band_i;
      c_q <= '0;
      k_q <= '0;
      rem_q <= '0;
    end else if (state_q != IDLE && bg_ready_i) begin
      if (adv) c_q <= c_q + 2'd1;
      if (state_q == OFFS) begin
        rem_q <= rem_nx;
        if (rem_nx == 5'd0) k_q <= k_q + 2'd1;
      end
    end

`ifdef SAO_OFFSET_CLIP_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if ((state_q == OFFS && over_of(off_q[(4*c_q+k_q)*OFF_W +: OFF_W])) || (state_q == TYPE && t == 2'd3)) err_q <= 1'b1;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule
